// File: rtl/router_pkg.sv
// Shared constants and state encoding for the 1x3 router packet controller.
package router_pkg;

  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned NUM_PORTS = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = ADDR_W'(3);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router: header decode, payload load,
// FIFO-full stall and parity check, with Moore strobes to router_reg.
module router_fsm
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy
);

  localparam int unsigned ADDR_SPACE = 1 << ADDR_W;

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_SPACE-1:0]  empty_ext;
  logic [ADDR_SPACE-1:0]  soft_ext;
  logic                   addr_ok;
  logic                   sel_empty;
  logic                   soft_hit;

  // Pad per-port flags to the full address space so the invalid address reads as 0.
  assign empty_ext = ADDR_SPACE'(fifo_empty);
  assign soft_ext  = ADDR_SPACE'(soft_reset);
  assign addr_ok   = pkt_valid && (data_in != ADDR_INVALID);
  assign sel_empty = (state == DECODE_ADDRESS) ? empty_ext[data_in] : empty_ext[addr_q];
  assign soft_hit  = soft_ext[addr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DECODE_ADDRESS;
    end else begin
      state <= state_next;
    end
  end

  // Destination is captured only when a valid header is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
    end else if (state == DECODE_ADDRESS && addr_ok) begin
      addr_q <= data_in;
    end
  end

  always_comb begin
    state_next    = state;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b0;

    if (soft_hit && state != DECODE_ADDRESS) begin
      state_next = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (addr_ok) begin
            state_next = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty) begin
            state_next = LOAD_FIRST_DATA;
          end
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full) begin
            state_next = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_next = LOAD_PARITY;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_next = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_next = DECODE_ADDRESS;
          end else if (low_packet_valid) begin
            state_next = LOAD_PARITY;
          end else begin
            state_next = LOAD_DATA;
          end
        end
        LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end

    // Moore output decode from the current state only.
    case (state)
      DECODE_ADDRESS: detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      WAIT_TILL_EMPTY: busy = 1'b1;
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      default: detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; outputs compared as one
// vector {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}.
module tb_router_fsm;
  import router_pkg::*;

  // Expected output vectors per state, written out from the output table.
  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0011;
  localparam logic [7:0] E_LD  = 8'b0010_0010;
  localparam logic [7:0] E_LP  = 8'b0000_0011;
  localparam logic [7:0] E_FF  = 8'b0000_1001;
  localparam logic [7:0] E_LAF = 8'b0001_0011;
  localparam logic [7:0] E_WTE = 8'b0000_0001;
  localparam logic [7:0] E_CPE = 8'b0000_0101;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_packet_valid;
  logic                 detect_add, lfd_state, ld_state, laf_state;
  logic                 full_state, rst_int_reg, write_enb_reg, busy;
  logic [7:0]           outs;

  int checks = 0;
  int errors = 0;

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  assign outs = {detect_add, lfd_state, ld_state, laf_state,
                 full_state, rst_int_reg, write_enb_reg, busy};

  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = '0; parity_done = 1'b0; low_packet_valid = 1'b0;
    step(); step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL reset: got %b exp %b", outs, E_DA); end
    reset = 1'b0;
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL idle_after_reset: got %b exp %b", outs, E_DA); end
  endtask

  task automatic test_basic_packet();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b111;
    step();
    checks++; if (outs !== E_LFD) begin errors++; $display("FAIL basic_lfd: got %b exp %b", outs, E_LFD); end
    step();
    checks++; if (outs !== E_LD) begin errors++; $display("FAIL basic_ld: got %b exp %b", outs, E_LD); end
    step();
    checks++; if (outs !== E_LD) begin errors++; $display("FAIL basic_ld_hold: got %b exp %b", outs, E_LD); end
    pkt_valid = 1'b0;
    step();
    checks++; if (outs !== E_LP) begin errors++; $display("FAIL basic_lp: got %b exp %b", outs, E_LP); end
    step();
    checks++; if (outs !== E_CPE) begin errors++; $display("FAIL basic_cpe: got %b exp %b", outs, E_CPE); end
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL basic_da: got %b exp %b", outs, E_DA); end
  endtask

  task automatic test_wait_empty();
    pkt_valid = 1'b1; data_in = 2'b01; fifo_empty = 3'b101;
    step();
    checks++; if (outs !== E_WTE) begin errors++; $display("FAIL wait_enter: got %b exp %b", outs, E_WTE); end
    // Only the latched port's flag may release the wait.
    data_in = 2'b00;
    step();
    checks++; if (outs !== E_WTE) begin errors++; $display("FAIL wait_hold: got %b exp %b", outs, E_WTE); end
    fifo_empty = 3'b111;
    step();
    checks++; if (outs !== E_LFD) begin errors++; $display("FAIL wait_release: got %b exp %b", outs, E_LFD); end
    step();
    checks++; if (outs !== E_LD) begin errors++; $display("FAIL wait_ld: got %b exp %b", outs, E_LD); end
  endtask

  task automatic test_fifo_full();
    fifo_full = 1'b1; pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (outs !== E_FF) begin errors++; $display("FAIL full_cycle%0d: got %b exp %b", i, outs, E_FF); end
    end
    fifo_full = 1'b0; pkt_valid = 1'b1;
    step();
    checks++; if (outs !== E_LAF) begin errors++; $display("FAIL full_laf: got %b exp %b", outs, E_LAF); end
    step();
    checks++; if (outs !== E_LD) begin errors++; $display("FAIL full_back_ld: got %b exp %b", outs, E_LD); end
  endtask

  task automatic test_laf_exits();
    fifo_full = 1'b1; step(); fifo_full = 1'b0; step();
    checks++; if (outs !== E_LAF) begin errors++; $display("FAIL lpv_laf: got %b exp %b", outs, E_LAF); end
    low_packet_valid = 1'b1;
    step();
    checks++; if (outs !== E_LP) begin errors++; $display("FAIL lpv_lp: got %b exp %b", outs, E_LP); end
    low_packet_valid = 1'b0;
    step();
    checks++; if (outs !== E_CPE) begin errors++; $display("FAIL lpv_cpe: got %b exp %b", outs, E_CPE); end
    fifo_full = 1'b1;
    step();
    checks++; if (outs !== E_FF) begin errors++; $display("FAIL cpe_full: got %b exp %b", outs, E_FF); end
    fifo_full = 1'b0;
    step();
    checks++; if (outs !== E_LAF) begin errors++; $display("FAIL cpe_full_laf: got %b exp %b", outs, E_LAF); end
    parity_done = 1'b1;
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL pd_da: got %b exp %b", outs, E_DA); end
    parity_done = 1'b0; pkt_valid = 1'b0;
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL pd_idle: got %b exp %b", outs, E_DA); end
  endtask

  task automatic test_invalid_addr();
    pkt_valid = 1'b1; data_in = 2'b11; fifo_empty = 3'b111;
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL invalid_1: got %b exp %b", outs, E_DA); end
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL invalid_2: got %b exp %b", outs, E_DA); end
  endtask

  task automatic test_soft_reset();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b111;
    step(); step();
    checks++; if (outs !== E_LD) begin errors++; $display("FAIL sr_setup_ld: got %b exp %b", outs, E_LD); end
    fifo_full = 1'b1;
    step();
    checks++; if (outs !== E_FF) begin errors++; $display("FAIL sr_setup_ff: got %b exp %b", outs, E_FF); end
    soft_reset = 3'b001;
    step();
    checks++; if (outs !== E_FF) begin errors++; $display("FAIL sr_other_port: got %b exp %b", outs, E_FF); end
    soft_reset = 3'b100;
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL sr_own_port: got %b exp %b", outs, E_DA); end
    soft_reset = '0; fifo_full = 1'b0; pkt_valid = 1'b0;
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL sr_idle: got %b exp %b", outs, E_DA); end
  endtask

  task automatic test_back_to_back();
    pkt_valid = 1'b1; data_in = 2'b00; fifo_empty = 3'b001;
    step();
    checks++; if (outs !== E_LFD) begin errors++; $display("FAIL b2b_lfd: got %b exp %b", outs, E_LFD); end
    // fifo_full wins over pkt_valid falling on the same edge.
    pkt_valid = 1'b0; fifo_full = 1'b1;
    step();
    checks++; if (outs !== E_LD) begin errors++; $display("FAIL b2b_ld: got %b exp %b", outs, E_LD); end
    step();
    checks++; if (outs !== E_FF) begin errors++; $display("FAIL b2b_full_wins: got %b exp %b", outs, E_FF); end
    fifo_full = 1'b0; reset = 1'b1;
    step();
    checks++; if (outs !== E_DA) begin errors++; $display("FAIL mid_reset: got %b exp %b", outs, E_DA); end
    reset = 1'b0; pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b011;
    step();
    checks++; if (outs !== E_WTE) begin errors++; $display("FAIL post_reset_wte: got %b exp %b", outs, E_WTE); end
    // After reset addr_q restarts at 0; soft_reset[0] must not disturb the new port-2 packet.
    soft_reset = 3'b001;
    step();
    checks++; if (outs !== E_WTE) begin errors++; $display("FAIL post_reset_sr0: got %b exp %b", outs, E_WTE); end
    soft_reset = '0;
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_wait_empty();
    test_fifo_full();
    test_laf_exits();
    test_invalid_addr();
    test_soft_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-level controller for the 1x3 router.
- Sits directly upstream of router_reg and drives its load-control strobes: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Also drives write_enb_reg to the three output FIFOs and busy back to the source.
- Tracks one packet at a time from header decode through parity check, and stalls on FIFO-full or a non-empty destination.

Parameters:
- ADDR_W, 2, width of the destination address field (data_in[1:0]).
- NUM_PORTS, 3, number of output ports; address 2'b11 is invalid.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; forces DECODE_ADDRESS.
- pkt_valid  in  1  source asserts while header/payload bytes are valid.
- data_in  in  ADDR_W  low bits of the current byte; sampled as the address in DECODE_ADDRESS.
- fifo_full  in  1  full flag of the currently selected FIFO.
- fifo_empty  in  NUM_PORTS  per-port empty flags; bit n = FIFO n.
- soft_reset  in  NUM_PORTS  per-port timeout resets from the synchronizer.
- parity_done  in  1  from router_reg: parity byte has been captured.
- low_packet_valid  in  1  from router_reg: pkt_valid fell while the FIFO was full.
- detect_add  out  1  high in DECODE_ADDRESS.
- lfd_state  out  1  high in LOAD_FIRST_DATA.
- ld_state  out  1  high in LOAD_DATA.
- laf_state  out  1  high in LOAD_AFTER_FULL.
- full_state  out  1  high in FIFO_FULL_STATE.
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  out  1  FIFO write enable; high in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY.
- busy  out  1  high in every state except DECODE_ADDRESS and LOAD_DATA.

Behaviour:
- State register: 3 bits. All outputs are Moore, decoded combinationally from the state register only.
- Reset values (state = DECODE_ADDRESS): detect_add=1; all other outputs 0; addr_q=0.
- addr_q latches data_in on a clock edge in DECODE_ADDRESS when pkt_valid=1 and data_in != 2'b11. It holds for the rest of the packet.
- sel_empty = fifo_empty[addr_q], except in DECODE_ADDRESS, where fifo_empty[data_in] is used.
- Priority on every edge: reset > soft_reset[addr_q] (any state except DECODE_ADDRESS; goes to DECODE_ADDRESS) > normal transitions.
- DECODE_ADDRESS:
  - pkt_valid, data_in != 3, sel_empty -> LOAD_FIRST_DATA.
  - pkt_valid, data_in != 3, !sel_empty -> WAIT_TILL_EMPTY.
  - Otherwise stay. Address 3 is dropped; busy stays 0.
- WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: unconditional -> LOAD_DATA (exactly 1 cycle).
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full wins when it coincides with pkt_valid falling.
- FIFO_FULL_STATE: fifo_full -> stay; else -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - !parity_done and low_packet_valid -> LOAD_PARITY.
  - Otherwise -> LOAD_DATA.
- LOAD_PARITY: unconditional -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Unused encodings -> DECODE_ADDRESS on the next edge.
- Latency: first payload byte is written 2 edges after the header is accepted (DA -> LFD -> LD).
- Reset asserted mid-packet returns to DECODE_ADDRESS on the same edge with reset outputs. No partial state survives.
- soft_reset on a non-selected port is ignored.

Decomposition:
- Shared package router_pkg holds:
  - the state encoding constants (DECODE_ADDRESS=0, LOAD_FIRST_DATA=1, LOAD_DATA=2, LOAD_PARITY=3, FIFO_FULL_STATE=4, LOAD_AFTER_FULL=5, WAIT_TILL_EMPTY=6, CHECK_PARITY_ERROR=7);
  - ADDR_W;
  - NUM_PORTS;
  - the constant ADDR_INVALID=2'b11.
- No sub-module. Use a single module with a state register, next-state logic, addr_q and an output decode.

Test Plan:
- Reset, then pkt_valid=1, data_in=2'b10, fifo_empty=3'b111:
  - next edge: lfd_state=1, busy=1, write_enb_reg=1;
  - following edge: ld_state=1, busy=0.
- In LOAD_DATA drop pkt_valid with fifo_full=0:
  - sequence LOAD_PARITY (write_enb_reg=1, busy=1), then CHECK_PARITY_ERROR (rst_int_reg=1), then DECODE_ADDRESS (detect_add=1).
- pkt_valid=1, data_in=2'b01, fifo_empty=3'b101:
  - enters WAIT_TILL_EMPTY (busy=1, write_enb_reg=0);
  - set fifo_empty[1]=1 -> next edge lfd_state=1.
- In LOAD_DATA assert fifo_full for 3 cycles:
  - full_state=1 for 3 cycles;
  - then laf_state=1 one cycle;
  - with parity_done=0 and low_packet_valid=0, returns to ld_state=1.
- In LOAD_AFTER_FULL:
  - low_packet_valid=1 -> LOAD_PARITY;
  - separate run with parity_done=1 -> DECODE_ADDRESS.
- Header data_in=2'b11 with pkt_valid=1 -> stays in DECODE_ADDRESS, busy=0.
- soft_reset[2]=1 in FIFO_FULL_STATE with addr_q=2 -> DECODE_ADDRESS next edge.
- soft_reset[0] with addr_q=2 -> no effect.
